booth_pp_accumulator: RTL
=========================

# booth_pp_accumulator

Multi-cycle accumulator that sums the 13 radix-4 Booth partial products of a 24x24 multiply into the 48-bit product. It sits directly downstream of the Booth partial-product generator in the multiplier datapath. It is the area-lean alternative to a full Wallace tree. It accepts one partial-product set per handshake, accumulates PP_PER_CYCLE partial products per clock, and presents the product under a valid/ready handshake.

## Interface
- PP_PER_CYCLE, 1, partial products added per clock; legal values 1 or 2.
- iclk  input  1  clock; all state updates on the rising edge.
- irst_n  input  1  reset, asynchronous, active-low.
- ipp_valid  input  1  partial-product set on ipp is valid.
- opp_ready  output  1  block can accept a set; high only in IDLE.
- ipp  input  338  13 partial products, 26 bits each, two's complement.
  - pp[k] = ipp[26k+25:26k], k = 0..12; pp[k] has weight 4^k.
- oproduct_valid  output  1  oproduct holds a completed result.
- iproduct_ready  input  1  downstream accepts oproduct.
- oproduct  output  48  accumulated product, modulo 2^48.
- obusy  output  1  high in ACC or DONE.

## Operation
- Arithmetic:
  - oproduct = sum over k of (sign-extend pp[k] from bit 25 to 48 bits) << 2k, truncated to 48 bits.
  - This gives the correct signed or unsigned 24x24 product for any set produced by the Booth generator.
- FSM states: IDLE, ACC, DONE. Reset state is IDLE.
- IDLE:
  - opp_ready = 1.
  - On ipp_valid & opp_ready: register all 13 partial products, clear the accumulator, set step counter cnt = 0, go to ACC.
- ACC, PP_PER_CYCLE = 1:
  - Each cycle: acc += ext(pp[cnt]) << 2cnt; cnt++.
  - After the cycle that adds pp[12], go to DONE.
- ACC, PP_PER_CYCLE = 2:
  - Each cycle adds pp[2c] and pp[2c+1], where c = cnt.
  - The final cycle (c = 6) adds pp[12] only.
  - Then go to DONE.
- DONE:
  - oproduct_valid = 1. oproduct and oproduct_valid are held stable until iproduct_ready is seen high.
  - On oproduct_valid & iproduct_ready: go to IDLE.
- ipp is sampled only on the accept edge. Changes to ipp during ACC or DONE have no effect.
- ipp_valid while not in IDLE is ignored (opp_ready = 0); the upstream holds its set.
- No back-to-back overlap: a new set is accepted no earlier than the cycle after the DONE handshake.
- Accumulator: 48 bits; overflow above bit 47 is discarded.
- Reset values: opp_ready = 0 while irst_n is low, then 1 once in IDLE. oproduct_valid = 0, oproduct = 0, obusy = 0, cnt = 0.

## Timing
- Accept edge is t0. State is ACC from t0.
- PP_PER_CYCLE = 1: ACC lasts 13 cycles; oproduct_valid rises at the edge t0+13.
- PP_PER_CYCLE = 2: ACC lasts 7 cycles; oproduct_valid rises at t0+7.
- With iproduct_ready held high, oproduct_valid stays high for exactly 1 cycle. opp_ready is then high on the following cycle.
- Minimum initiation interval, including the IDLE cycle: 15 cycles (PP_PER_CYCLE = 1), 9 cycles (PP_PER_CYCLE = 2).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset asserted in any state (mid-ACC or DONE):
  - All outputs clear immediately; the in-flight result is discarded.
  - After deassertion the block is in IDLE with opp_ready = 1 on the first clock.

## Test plan
- Unsigned 3x5:
  - Stimulus: pp0 = 26'h0000003, pp1 = 26'h0000003, others 0.
  - Response: oproduct = 48'h00000000000F, valid at t0+13 (PP_PER_CYCLE = 1) and t0+7 (PP_PER_CYCLE = 2).
- Signed -1 x 1:
  - Stimulus: pp0 = 26'h3FFFFFF, others 0.
  - Response: oproduct = 48'hFFFFFFFFFFFF.
- Unsigned max, 0xFFFFFF x 0xFFFFFF:
  - Stimulus: the generator's pp set.
  - Response: oproduct = 48'hFFFFFE000001.
  - Randomized: 10k random signed/unsigned operand pairs through the generator and this block; every oproduct matches the reference a*b mod 2^48.
- Backpressure:
  - Stimulus: hold iproduct_ready = 0 for 20 cycles after valid.
  - Response: oproduct and oproduct_valid stable throughout; opp_ready = 0; ipp_valid pulses ignored.
  - After release: one handshake, then IDLE.
- Input stability:
  - Stimulus: change ipp every cycle during ACC.
  - Response: result equals the set captured at t0.
- Reset mid-operation:
  - Stimulus: assert irst_n = 0 at t0+5.
  - Response: oproduct_valid = 0, oproduct = 0, obusy = 0 immediately.
  - After release: a new set (3x5) completes with 48'h00000000000F.

Source files
------------

// File: rtl/booth_pp_accumulator.sv
// booth_pp_accumulator
// Multi-cycle adder for the 13 radix-4 Booth partial products of a 24x24
// multiply. A partial-product set is captured on the accept edge, summed
// PP_PER_CYCLE terms per clock into a 48-bit accumulator, and the product
// is presented under a valid/ready handshake. All outputs are registered.
module booth_pp_accumulator #(
    parameter int PP_PER_CYCLE = 1
) (
    input  logic         iclk,
    input  logic         irst_n,
    input  logic         ipp_valid,
    output logic         opp_ready,
    input  logic [337:0] ipp,
    output logic         oproduct_valid,
    input  logic         iproduct_ready,
    output logic [47:0]  oproduct,
    output logic         obusy
);

    localparam int          NUM_PP   = 13;
    localparam int          PP_W     = 26;
    localparam logic [3:0]  LAST_CNT = (PP_PER_CYCLE == 2) ? 4'd6 : 4'd12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PP_W-1:0]    pp_q [NUM_PP];
    logic [PP_W-1:0]    pp_d [NUM_PP];
    logic [47:0]        acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [47:0]        oproduct_q, oproduct_d;
    logic               oproduct_valid_q, oproduct_valid_d;
    logic               opp_ready_q, opp_ready_d;
    logic               obusy_q, obusy_d;

    logic [3:0]         idx_lo_s;
    logic [3:0]         idx_hi_s;
    logic [47:0]        term_lo_s;
    logic [47:0]        term_hi_s;

    // Sign-extend a partial product to 48 bits and place it at weight 4^k.
    function automatic logic [47:0] pp_term(input logic [PP_W-1:0] pp,
                                            input logic [3:0]      k);
        logic [47:0] ext_v;
        ext_v = {{(48-PP_W){pp[PP_W-1]}}, pp};
        return ext_v << {k, 1'b0};
    endfunction

    // Select the partial product(s) consumed in the current ACC step.
    always_comb begin
        idx_lo_s  = 4'd0;
        idx_hi_s  = 4'd0;
        term_lo_s = 48'd0;
        term_hi_s = 48'd0;
        if (PP_PER_CYCLE == 2) begin
            idx_lo_s = {cnt_q[2:0], 1'b0};
        end else begin
            idx_lo_s = cnt_q;
        end
        idx_hi_s  = idx_lo_s + 4'd1;
        term_lo_s = pp_term(pp_q[idx_lo_s], idx_lo_s);
        // The last two-per-cycle step has only pp[12]; no pp[13] exists.
        if ((PP_PER_CYCLE == 2) && (idx_hi_s <= 4'd12)) begin
            term_hi_s = pp_term(pp_q[idx_hi_s], idx_hi_s);
        end else begin
            term_hi_s = 48'd0;
        end
    end

    // Next-state and datapath update for the IDLE/ACC/DONE controller.
    always_comb begin
        state_d    = state_q;
        pp_d       = pp_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        oproduct_d = oproduct_q;
        case (state_q)
            IDLE: begin
                if (ipp_valid && opp_ready_q) begin
                    for (int k = 0; k < NUM_PP; k++) begin
                        pp_d[k] = ipp[PP_W*k +: PP_W];
                    end
                    acc_d   = 48'd0;
                    cnt_d   = 4'd0;
                    state_d = ACC;
                end else begin
                    state_d = IDLE;
                end
            end
            ACC: begin
                acc_d = acc_q + term_lo_s + term_hi_s;
                if (cnt_q == LAST_CNT) begin
                    cnt_d      = 4'd0;
                    oproduct_d = acc_d;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                // oproduct_valid is always high here, so ready alone completes.
                if (iproduct_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered copies of the upcoming state.
        opp_ready_d      = (state_d == IDLE);
        obusy_d          = (state_d != IDLE);
        oproduct_valid_d = (state_d == DONE);
    end

    // FSM state register.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int k = 0; k < NUM_PP; k++) begin
                pp_q[k] <= {PP_W{1'b0}};
            end
            acc_q            <= 48'd0;
            cnt_q            <= 4'd0;
            oproduct_q       <= 48'd0;
            oproduct_valid_q <= 1'b0;
            opp_ready_q      <= 1'b0;
            obusy_q          <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_PP; k++) begin
                pp_q[k] <= pp_d[k];
            end
            acc_q            <= acc_d;
            cnt_q            <= cnt_d;
            oproduct_q       <= oproduct_d;
            oproduct_valid_q <= oproduct_valid_d;
            opp_ready_q      <= opp_ready_d;
            obusy_q          <= obusy_d;
        end
    end

    assign opp_ready      = opp_ready_q;
    assign oproduct_valid = oproduct_valid_q;
    assign oproduct       = oproduct_q;
    assign obusy          = obusy_q;

endmodule
